// File: rtl/pipe_chain.sv
// In-order pipeline backbone: STAGES slots of payload + dst-reg tag, stage 0 youngest.
// Per-stage stall with bubble insertion, ranged flush, occupancy count and a forwarding lookup.
module pipe_chain #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned STAGES = 5,
  localparam int unsigned CNT_W = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_wr,
  output logic              in_ready,
  input  logic [STAGES-1:0] stall_req,
  input  logic              flush_en,
  input  logic [3:0]        flush_upto,
  output logic              out_valid,
  output logic              out_fire,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_wr,
  input  logic [TAG_W-1:0]  lk_tag,
  output logic              lk_hit,
  output logic [3:0]        lk_stage,
  output logic [DATA_W-1:0] lk_data,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int unsigned LAST     = STAGES - 1;
  localparam logic [3:0]  LAST_IDX = 4'(LAST);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] wr_q, wr_d;
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] kill;
  logic [3:0]        flush_k;

  always_comb begin
    flush_k = (flush_upto > LAST_IDX) ? LAST_IDX : flush_upto;
  end

  // A stall freezes its own stage and everything younger behind it.
  always_comb begin
    hold = '0;
    kill = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      hold[i] = |(stall_req >> i);
      kill[i] = flush_en && (4'(i) <= flush_k);
    end
  end

  assign in_ready = ~hold[0] & ~flush_en;

  always_comb begin
    valid_d = valid_q;
    wr_d    = wr_q;
    tag_d   = tag_q;
    data_d  = data_q;

    if (kill[0]) begin
      valid_d[0] = 1'b0;
      wr_d[0]    = 1'b0;
    end else if (!hold[0]) begin
      valid_d[0] = in_valid;
      wr_d[0]    = in_valid & in_wr;
      tag_d[0]   = in_tag;
      data_d[0]  = in_data;
    end

    for (int i = 1; i < int'(STAGES); i++) begin
      if (kill[i]) begin
        valid_d[i] = 1'b0;
        wr_d[i]    = 1'b0;
      end else if (!hold[i]) begin
        // A held or flushed predecessor leaves a bubble behind the advancing stage.
        if (hold[i-1] || kill[i-1]) begin
          valid_d[i] = 1'b0;
          wr_d[i]    = 1'b0;
        end else begin
          valid_d[i] = valid_q[i-1];
          wr_d[i]    = wr_q[i-1];
          tag_d[i]   = tag_q[i-1];
          data_d[i]  = data_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      wr_q    <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      wr_q    <= wr_d;
      for (int i = 0; i < int'(STAGES); i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin
    out_valid = valid_q[LAST];
    out_fire  = valid_q[LAST] & ~stall_req[LAST];
    out_data  = data_q[LAST];
    out_tag   = tag_q[LAST];
    out_wr    = wr_q[LAST];
  end

  // Scan oldest to youngest so the youngest matching stage overrides.
  always_comb begin
    lk_hit   = 1'b0;
    lk_stage = '0;
    lk_data  = '0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      if (valid_q[i] && wr_q[i] && (tag_q[i] == lk_tag) && (lk_tag != '0)) begin
        lk_hit   = 1'b1;
        lk_stage = 4'(i);
        lk_data  = data_q[i];
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      occupancy = occupancy + CNT_W'(valid_q[i]);
    end
  end

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain (STAGES=5): a cycle-by-cycle vector table followed by a
// hand-written asynchronous-reset sequence.
module tb_pipe_chain;

  localparam int DW = 32;
  localparam int TW = 5;
  localparam int NS = 5;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [TW-1:0] in_tag;
  logic          in_wr;
  logic          in_ready;
  logic [NS-1:0] stall_req;
  logic          flush_en;
  logic [3:0]    flush_upto;
  logic          out_valid;
  logic          out_fire;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic          out_wr;
  logic [TW-1:0] lk_tag;
  logic          lk_hit;
  logic [3:0]    lk_stage;
  logic [DW-1:0] lk_data;
  logic [CW-1:0] occupancy;

  pipe_chain #(.DATA_W(DW), .TAG_W(TW), .STAGES(NS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_tag     (in_tag),
    .in_wr      (in_wr),
    .in_ready   (in_ready),
    .stall_req  (stall_req),
    .flush_en   (flush_en),
    .flush_upto (flush_upto),
    .out_valid  (out_valid),
    .out_fire   (out_fire),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_wr     (out_wr),
    .lk_tag     (lk_tag),
    .lk_hit     (lk_hit),
    .lk_stage   (lk_stage),
    .lk_data    (lk_data),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          wr;
    logic [NS-1:0] stall;
    logic          fl;
    logic [3:0]    fu;
    logic [TW-1:0] lk;
    logic          rdy;
    logic          ov;
    logic          of;
    logic [TW-1:0] otag;
    logic [DW-1:0] odata;
    logic [CW-1:0] occ;
    logic          hit;
    logic [3:0]    lst;
    logic [DW-1:0] ldat;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [DW-1:0] d(input int t);
    return 32'h100 + DW'(t);
  endfunction

  task automatic add(input logic v, input logic [TW-1:0] tag, input logic [DW-1:0] data,
                     input logic wr, input logic [NS-1:0] stall, input logic fl,
                     input logic [3:0] fu, input logic [TW-1:0] lk, input logic rdy,
                     input logic ov, input logic of, input logic [TW-1:0] otag,
                     input logic [DW-1:0] odata, input logic [CW-1:0] occ, input logic hit,
                     input logic [3:0] lst, input logic [DW-1:0] ldat);
    vec_t r;
    r.v = v; r.tag = tag; r.data = data; r.wr = wr; r.stall = stall; r.fl = fl; r.fu = fu;
    r.lk = lk; r.rdy = rdy; r.ov = ov; r.of = of; r.otag = otag; r.odata = odata;
    r.occ = occ; r.hit = hit; r.lst = lst; r.ldat = ldat;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [TW-1:0] tag, input logic [DW-1:0] data,
                       input logic wr, input logic [NS-1:0] stall, input logic fl,
                       input logic [3:0] fu, input logic [TW-1:0] lk);
    in_valid = v; in_tag = tag; in_data = data; in_wr = wr;
    stall_req = stall; flush_en = fl; flush_upto = fu; lk_tag = lk;
  endtask

  int fires;

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 5'd1);
    repeat (2) @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_fire", 32'(out_fire), 32'd0);
    chk("reset lk_hit", 32'(lk_hit), 32'd0);
    chk("reset occupancy", 32'(occupancy), 32'd0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back entries, retire 5 cycles after acceptance
    add(1, 1, d(1), 1, 0, 0, 0, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0);
    add(1, 2, d(2), 1, 0, 0, 0, 0, 1, 0, 0, 0, 0,    1, 0, 0, 0);
    add(1, 3, d(3), 1, 0, 0, 0, 0, 1, 0, 0, 0, 0,    2, 0, 0, 0);
    add(0, 0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0, 0,    3, 0, 0, 0);
    add(0, 0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0, 0,    3, 0, 0, 0);
    add(0, 0, 0,    0, 0, 0, 0, 0, 1, 1, 1, 1, d(1), 3, 0, 0, 0);
    add(0, 0, 0,    0, 0, 0, 0, 0, 1, 1, 1, 2, d(2), 2, 0, 0, 0);
    add(0, 0, 0,    0, 0, 0, 0, 0, 1, 1, 1, 3, d(3), 1, 0, 0, 0);
    add(0, 0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0);
    // Stall stage 2 for two cycles with an entry offered at the input
    add(1, 4, d(4), 1, 0,        0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 5, d(5), 1, 0,        0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 6, d(6), 1, 0,        0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0);
    add(1, 7, d(7), 1, 5'b00100, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    add(1, 7, d(7), 1, 5'b00100, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    add(1, 7, d(7), 1, 0,        0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0);
    add(0, 0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0, 0,    4, 0, 0, 0);
    add(0, 0, 0,    0, 0, 0, 0, 0, 1, 1, 1, 4, d(4), 4, 0, 0, 0);
    add(0, 0, 0,    0, 0, 0, 0, 0, 1, 1, 1, 5, d(5), 3, 0, 0, 0);
    add(0, 0, 0,    0, 0, 0, 0, 0, 1, 1, 1, 6, d(6), 2, 0, 0, 0);
    add(0, 0, 0,    0, 0, 0, 0, 0, 1, 1, 1, 7, d(7), 1, 0, 0, 0);
    // Fill all five stages, then flush 0..1 while the oldest retires
    add(1, 1, d(1), 1, 0, 0, 0, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0);
    add(1, 2, d(2), 1, 0, 0, 0, 0, 1, 0, 0, 0, 0,    1, 0, 0, 0);
    add(1, 3, d(3), 1, 0, 0, 0, 0, 1, 0, 0, 0, 0,    2, 0, 0, 0);
    add(1, 4, d(4), 1, 0, 0, 0, 0, 1, 0, 0, 0, 0,    3, 0, 0, 0);
    add(1, 5, d(5), 1, 0, 0, 0, 0, 1, 0, 0, 0, 0,    4, 0, 0, 0);
    add(1, 9, d(9), 1, 0, 1, 1, 0, 0, 1, 1, 1, d(1), 5, 0, 0, 0);
    add(0, 0, 0,    0, 0, 0, 0, 0, 1, 1, 1, 2, d(2), 2, 0, 0, 0);
    add(0, 0, 0,    0, 0, 0, 0, 0, 1, 1, 1, 3, d(3), 1, 0, 0, 0);
    add(0, 0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0);
    // Forwarding lookup: tag 7 in stages 1 and 3, tag 0 in stages 0 and 2
    add(1, 7, 32'hBBBB, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 32'h1111, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 7, 32'hAAAA, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0);
    add(1, 0, 32'h2222, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0);
    add(0, 0, 0, 0, 5'b10000, 0, 0, 7, 0, 0, 0, 0, 0, 4, 1, 1, 32'hAAAA);
    add(0, 0, 0, 0, 5'b10000, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0);
    // Flush 0..2 while stage 1 stalls: flush wins, stage 3 still advances
    add(1, 9, d(9), 1, 5'b00010, 1, 2, 7, 0, 0, 0, 0, 0, 4, 1, 1, 32'hAAAA);
    add(0, 0, 0, 0, 0, 0, 0, 7, 1, 1, 1, 7, 32'hBBBB, 1, 1, 4, 32'hBBBB);
    // Out-of-range flush_upto clamps to the last stage
    add(1, 1, d(1), 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2, d(2), 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 3, d(3), 1, 0, 1, 15, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    add(0, 0, 0,    0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Non-writing entry never forwards; a stalled oldest stage does not fire
    add(1, 4, d(4), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 5'b10000, 0, 0, 0, 0, 1, 0, 4, d(4), 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4, d(4), 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].tag, vecs[i].data, vecs[i].wr, vecs[i].stall, vecs[i].fl,
            vecs[i].fu, vecs[i].lk);
      #2;
      chk($sformatf("r%0d in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      chk($sformatf("r%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("r%0d out_fire", i), 32'(out_fire), 32'(vecs[i].of));
      chk($sformatf("r%0d occupancy", i), 32'(occupancy), 32'(vecs[i].occ));
      chk($sformatf("r%0d lk_hit", i), 32'(lk_hit), 32'(vecs[i].hit));
      chk($sformatf("r%0d lk_stage", i), 32'(lk_stage), 32'(vecs[i].lst));
      chk($sformatf("r%0d lk_data", i), lk_data, vecs[i].ldat);
      if (vecs[i].ov) begin
        chk($sformatf("r%0d out_tag", i), 32'(out_tag), 32'(vecs[i].otag));
        chk($sformatf("r%0d out_data", i), out_data, vecs[i].odata);
      end
    end

    // Asynchronous reset with four entries in flight
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      drive(1, 5'(t), d(t), 1, 0, 0, 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    chk("pre-rst occupancy", 32'(occupancy), 32'd4);
    chk("pre-rst out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst occupancy", 32'(occupancy), 32'd0);
    chk("rst out_fire", 32'(out_fire), 32'd0);
    fires = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b0;
      #2;
      if (out_fire) fires++;
    end
    chk("post-rst fire pulses", 32'(fires), 32'd0);
    chk("post-rst occupancy", 32'(occupancy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
